// File: rtl/ft_tx_arbiter_if.sv
// Request/FT-write bundle for ft_tx_arbiter: per-channel word streams in, one FT write stream out.
interface ft_tx_arbiter_if #(
    parameter int unsigned BUS_WIDTH = 16,
    parameter int unsigned CHANNELS  = 4
);
    logic [CHANNELS*BUS_WIDTH-1:0] req_data;
    logic [CHANNELS-1:0]           req_valid;
    logic [CHANNELS-1:0]           req_last;
    logic [CHANNELS-1:0]           req_ready;
    logic [BUS_WIDTH-1:0]          ui_din;
    logic [BUS_WIDTH/8-1:0]        ui_din_be;
    logic                          ui_din_valid;
    logic                          ui_din_full;
    logic [1:0]                    active_ch;
    logic                          busy;

    // arbiter side
    modport master (
        input  req_data, req_valid, req_last, ui_din_full,
        output req_ready, ui_din, ui_din_be, ui_din_valid, active_ch, busy
    );

    // requester / FT FIFO side
    modport slave (
        output req_data, req_valid, req_last, ui_din_full,
        input  req_ready, ui_din, ui_din_be, ui_din_valid, active_ch, busy
    );
endinterface

// File: rtl/ft_tx_arbiter.sv
// Round-robin arbiter framing per-channel bursts (header + data) into one FT write stream.
// Optional trailer word per burst is enabled by defining FT_ARB_TRAILER_EN.
module ft_tx_arbiter #(
    parameter int unsigned BUS_WIDTH = 16,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    ft_tx_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
`ifdef FT_ARB_TRAILER_EN
        ,
        TRAILER = 2'd3
`endif
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [1:0]           rr_ptr;
    logic [1:0]           active_ch;
    logic [1:0]           grant_ch;
    logic [1:0]           next_ptr;
    logic [7:0]           beat;
    logic                 busy;
    logic                 any_req;
    logic [BUS_WIDTH-1:0] sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic [CHANNELS-1:0]  sel_onehot;
    logic [BUS_WIDTH-1:0] header_word;
    logic [BUS_WIDTH-1:0] trailer_word;
    logic                 data_write;
    logic                 burst_end;
    logic [BUS_WIDTH-1:0] din;
    logic                 din_valid;
    logic [CHANNELS-1:0]  ready;

    // First requester at or after rr_ptr, scanning round-robin.
    always_comb begin
        any_req  = 1'b0;
        grant_ch = '0;
        for (int unsigned off = 0; off < CHANNELS; off++) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!any_req && bus.req_valid[i] &&
                    ((32'(rr_ptr) + off) % CHANNELS) == i) begin
                    any_req  = 1'b1;
                    grant_ch = 2'(i);
                end
            end
        end
    end

    always_comb begin
        sel_data   = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (active_ch == 2'(i)) begin
                sel_data      = bus.req_data[i*BUS_WIDTH +: BUS_WIDTH];
                sel_valid     = bus.req_valid[i];
                sel_last      = bus.req_last[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign next_ptr = 2'((32'(active_ch) + 1) % CHANNELS);

    always_comb begin
        header_word        = '0;
        header_word[15:0]  = {8'hA5, 6'd0, active_ch};
        trailer_word       = '0;
        trailer_word[15:0] = {8'h5A, beat};
    end

    always_comb begin
        state_next = state;
        din        = '0;
        din_valid  = 1'b0;
        ready      = '0;
        data_write = 1'b0;
        burst_end  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_next = HEADER;
            end
            HEADER: begin
                din       = header_word;
                din_valid = !bus.ui_din_full;
                if (!bus.ui_din_full) state_next = DATA;
            end
            DATA: begin
                din       = sel_data;
                ready     = bus.ui_din_full ? '0 : sel_onehot;
                din_valid = sel_valid && !bus.ui_din_full;
                if (din_valid) begin
                    data_write = 1'b1;
                    if (sel_last || (beat + 8'd1) == 8'(MAX_BURST)) begin
                        burst_end = 1'b1;
`ifdef FT_ARB_TRAILER_EN
                        state_next = TRAILER;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
`ifdef FT_ARB_TRAILER_EN
            TRAILER: begin
                din       = trailer_word;
                din_valid = !bus.ui_din_full;
                if (!bus.ui_din_full) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            active_ch <= '0;
            beat      <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            if (state == IDLE && any_req) begin
                active_ch <= grant_ch;
                beat      <= '0;
            end
            if (data_write) beat <= beat + 8'd1;
            if (burst_end) rr_ptr <= next_ptr;
        end
    end

    assign bus.ui_din       = din;
    assign bus.ui_din_valid = din_valid;
    assign bus.ui_din_be    = '1;
    assign bus.req_ready    = ready;
    assign bus.active_ch    = active_ch;
    assign bus.busy         = busy;

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed self-checking bench for ft_tx_arbiter (MAX_BURST=4, 16-bit, 4 channels).
module tb_ft_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ft_tx_arbiter_if #(.BUS_WIDTH(16), .CHANNELS(4)) bus ();

    ft_tx_arbiter #(.BUS_WIDTH(16), .CHANNELS(4), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] words[$];
    logic [15:0] expq[$];

    always @(negedge clk) begin
        if (rst_n && bus.ui_din_valid === 1'b1) words.push_back(bus.ui_din);
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [1:0]  ch;
        logic [15:0] data;
        logic        full;
        logic        e_valid;
        logic [15:0] e_din;
        logic [3:0]  e_ready;
        logic        e_busy;
        logic [1:0]  e_act;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Lane ch carries d; every other lane carries a distinct filler value.
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [1:0] ch, input logic [15:0] d);
        for (int i = 0; i < 4; i++)
            bus.req_data[i*16 +: 16] = (i == int'(ch)) ? d : 16'hDEA0 + 16'(i);
        bus.req_valid = v;
        bus.req_last  = l;
    endtask

    task automatic add_trl(input logic [7:0] n);
`ifdef FT_ARB_TRAILER_EN
        expq.push_back({8'h5A, n});
`else
        if (n == 8'hFF) $display("unused trailer count");
`endif
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 32'(words.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < words.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(words[i]), 32'(expq[i]));
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(4'b0, 4'b0, 2'd0, 16'h0);
        bus.ui_din_full = 1'b0;
        #2;
        chk({tag, "_rst_valid"}, 32'(bus.ui_din_valid), 32'd0);
        chk({tag, "_rst_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_rst_act"}, 32'(bus.active_ch), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        words.delete();
        expq.delete();
    endtask

    initial begin
        int idx0;
        bit done1;
        bit acc0;
        bit acc1;

        // cycle-by-cycle vectors: ch2 clean 3-word burst, then ch1 burst with a 5-cycle full stall
        tbl[0]  = '{4'b0100, 4'b0000, 2'd2, 16'h1111, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0100, 4'b0000, 2'd2, 16'h1111, 1'b0, 1'b1, 16'hA502, 4'b0000, 1'b1, 2'd2};
        tbl[2]  = '{4'b0100, 4'b0000, 2'd2, 16'h1111, 1'b0, 1'b1, 16'h1111, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b0100, 4'b0000, 2'd2, 16'h2222, 1'b0, 1'b1, 16'h2222, 4'b0100, 1'b1, 2'd2};
        tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 16'h3333, 1'b0, 1'b1, 16'h3333, 4'b0100, 1'b1, 2'd2};
`ifdef FT_ARB_TRAILER_EN
        tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 16'h0000, 1'b0, 1'b1, 16'h5A03, 4'b0000, 1'b1, 2'd2};
`else
        tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd2};
`endif
        tbl[6]  = '{4'b0010, 4'b0000, 2'd1, 16'h0AAA, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd2};
        tbl[7]  = '{4'b0010, 4'b0000, 2'd1, 16'h0AAA, 1'b0, 1'b1, 16'hA501, 4'b0000, 1'b1, 2'd1};
        tbl[8]  = '{4'b0011, 4'b0000, 2'd1, 16'h0AAA, 1'b0, 1'b1, 16'h0AAA, 4'b0010, 1'b1, 2'd1};
        for (int r = 9; r < 14; r++)
            tbl[r] = '{4'b0011, 4'b0000, 2'd1, 16'h0BBB, 1'b1, 1'b0, 16'h0BBB, 4'b0000, 1'b1, 2'd1};
        tbl[14] = '{4'b0010, 4'b0010, 2'd1, 16'h0BBB, 1'b0, 1'b1, 16'h0BBB, 4'b0010, 1'b1, 2'd1};
`ifdef FT_ARB_TRAILER_EN
        tbl[15] = '{4'b0000, 4'b0000, 2'd1, 16'h0000, 1'b0, 1'b1, 16'h5A02, 4'b0000, 1'b1, 2'd1};
`else
        tbl[15] = '{4'b0000, 4'b0000, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd1};
`endif

        bus.ui_din_full = 1'b0;
        drive(4'b0, 4'b0, 2'd0, 16'h0);
        #3;
        chk("init_valid", 32'(bus.ui_din_valid), 32'd0);
        chk("init_ready", 32'(bus.req_ready), 32'd0);
        chk("init_busy", 32'(bus.busy), 32'd0);
        chk("init_act", 32'(bus.active_ch), 32'd0);
        chk("init_be", 32'(bus.ui_din_be), 32'h3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].valid, tbl[r].last, tbl[r].ch, tbl[r].data);
            bus.ui_din_full = tbl[r].full;
            @(negedge clk);
            chk($sformatf("row%0d_valid", r), 32'(bus.ui_din_valid), 32'(tbl[r].e_valid));
            chk($sformatf("row%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].e_ready));
            chk($sformatf("row%0d_busy", r), 32'(bus.busy), 32'(tbl[r].e_busy));
            chk($sformatf("row%0d_act", r), 32'(bus.active_ch), 32'(tbl[r].e_act));
            if (tbl[r].e_valid || tbl[r].full)
                chk($sformatf("row%0d_din", r), 32'(bus.ui_din), 32'(tbl[r].e_din));
            @(posedge clk);
            #1;
        end

        // all channels always valid with single-word messages: grants 0,1,2,3,0
        do_reset("rr");
        for (int g = 0; g < 5; g++) begin
            expq.push_back(16'hA500 + 16'(g % 4));
            expq.push_back(16'hDEA0 + 16'(g % 4));
            add_trl(8'd1);
        end
        drive(4'b1111, 4'b1111, 2'd0, 16'hDEA0);
        for (int cyc = 0; cyc < 80 && words.size() < expq.size(); cyc++) @(posedge clk);
        #1;
        drive(4'b0, 4'b0, 2'd0, 16'h0);
        repeat (3) @(posedge clk);
        cmp_stream("rr");

        // MAX_BURST cutoff: ch0 streams 10 unterminated words, ch1 has one word
        do_reset("mb");
        expq.push_back(16'hA500);
        for (int k = 0; k < 4; k++) expq.push_back(16'h0E00 + 16'(k));
        add_trl(8'd4);
        expq.push_back(16'hA501);
        expq.push_back(16'h0F11);
        add_trl(8'd1);
        expq.push_back(16'hA500);
        for (int k = 4; k < 8; k++) expq.push_back(16'h0E00 + 16'(k));
        add_trl(8'd4);
        expq.push_back(16'hA500);
        expq.push_back(16'h0E08);
        expq.push_back(16'h0E09);
        idx0 = 0;
        done1 = 1'b0;
        for (int cyc = 0; cyc < 200 && words.size() < expq.size(); cyc++) begin
            bus.req_data[15:0]  = 16'h0E00 + 16'(idx0);
            bus.req_data[31:16] = 16'h0F11;
            bus.req_valid = {2'b00, !done1, idx0 < 10};
            bus.req_last  = 4'b0010;
            @(negedge clk);
            acc0 = bus.req_ready[0] && bus.req_valid[0];
            acc1 = bus.req_ready[1] && bus.req_valid[1];
            @(posedge clk);
            #1;
            if (acc0) idx0++;
            if (acc1) done1 = 1'b1;
        end
        bus.req_valid = {2'b00, !done1, idx0 < 10};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mb_wait_busy", 32'(bus.busy), 32'd1);
        chk("mb_wait_valid", 32'(bus.ui_din_valid), 32'd0);
        chk("mb_wait_act", 32'(bus.active_ch), 32'd0);
        cmp_stream("mb");

        // reset mid-burst after two of five words, then channel 3 requests
        do_reset("mr");
        idx0 = 0;
        for (int cyc = 0; cyc < 40 && words.size() < 3; cyc++) begin
            drive(4'b0100, (idx0 == 4) ? 4'b0100 : 4'b0000, 2'd2, 16'h2200 + 16'(idx0));
            @(negedge clk);
            acc0 = bus.req_ready[2] && bus.req_valid[2];
            @(posedge clk);
            #1;
            if (acc0) idx0++;
        end
        drive(4'b0100, 4'b0000, 2'd2, 16'h2200 + 16'(idx0));
        #1;
        chk("mr_pre_valid", 32'(bus.ui_din_valid), 32'd1);
        chk("mr_pre_din", 32'(bus.ui_din), 32'h2202);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.ui_din_valid), 32'd0);
        chk("mr_ready", 32'(bus.req_ready), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_act", 32'(bus.active_ch), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        words.delete();
        expq.delete();
        expq.push_back(16'hA503);
        expq.push_back(16'h3333);
        add_trl(8'd1);
        drive(4'b1000, 4'b1000, 2'd3, 16'h3333);
        for (int cyc = 0; cyc < 40 && words.size() < expq.size(); cyc++) @(posedge clk);
        #1;
        drive(4'b0, 4'b0, 2'd0, 16'h0);
        repeat (3) @(posedge clk);
        cmp_stream("mr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ft_tx_arbiter.md
FT_TX_ARBITER -- requirements
Module: ft_tx_arbiter

Interface
REQ-001 Parameters SHALL be:
  - BUS_WIDTH, default 16, data width (16 or 32).
  - CHANNELS, default 4, requester count (2..4).
  - MAX_BURST, default 64, maximum data words per grant (1..255).
REQ-002 Ports SHALL be:
  - clk  in  1  single clock, also the ft write-side clock.
  - rst_n  in  1  reset; asynchronous, active-low.
  - req_data  in  CHANNELS*BUS_WIDTH  per-channel data, channel i at bits [i*BUS_WIDTH +: BUS_WIDTH].
  - req_valid  in  CHANNELS  per-channel word valid.
  - req_last  in  CHANNELS  per-channel last word of message.
  - req_ready  out  CHANNELS  per-channel word accepted this cycle.
  - ui_din  out  BUS_WIDTH  word to ft write FIFO.
  - ui_din_be  out  BUS_WIDTH/8  byte enables, always all ones.
  - ui_din_valid  out  1  write strobe to ft FIFO.
  - ui_din_full  in  1  ft write FIFO full.
  - active_ch  out  2  currently granted channel.
  - busy  out  1  high in any state other than IDLE.

Function
REQ-003 States SHALL be IDLE, HEADER, DATA, and TRAILER (TRAILER only with the macro in REQ-017).
REQ-004 Arbitration in IDLE:
  - If any req_valid is set, grant the first requesting channel at or after rr_ptr, searching round-robin modulo CHANNELS.
  - Latch the grant into active_ch and go to HEADER on the next edge.
  - With no request, stay in IDLE.
REQ-005 Only active_ch SHALL be served until its burst ends; requests on other channels are ignored until the next IDLE.
REQ-006 HEADER state:
  - ui_din_valid = !ui_din_full.
  - ui_din = {8'hA5, zero pad, active_ch}, right-aligned.
  - Go to DATA on the edge where the header is written.
REQ-007 DATA state:
  - req_ready[active_ch] = !ui_din_full; ui_din_valid = req_valid[active_ch] && !ui_din_full; ui_din = req_data of active_ch.
  - All other req_ready bits SHALL be 0.
  - Path is combinational, zero latency.
REQ-008 Each written data word SHALL increment an 8-bit beat counter, which is cleared on entry to HEADER.
REQ-009 The burst SHALL end on the write of a word with req_last set, or on the write that makes the beat counter equal MAX_BURST, whichever comes first; the next state is then TRAILER if enabled, else IDLE.
REQ-010 On burst end, rr_ptr SHALL become (active_ch+1) mod CHANNELS; a MAX_BURST cutoff without req_last leaves that message open, and its remainder gets a new header on a later grant.
REQ-011 When ui_din_full is 1:
  - No write occurs and ui_din_valid = 0.
  - State, counter, and data are held with no loss or duplication.
REQ-012 When req_valid of the active channel drops mid-burst, DATA SHALL wait indefinitely with ui_din_valid = 0.
REQ-013 req_ready SHALL be 0 in IDLE, HEADER, and TRAILER.
REQ-014 busy and active_ch SHALL be registered; ui_din, ui_din_valid, and req_ready are combinational from state and inputs.

Reset
REQ-015 With rst_n low, the block SHALL asynchronously set state=IDLE, rr_ptr=0, active_ch=0, beat counter=0, and busy=0; ui_din_valid=0 and req_ready=0 follow combinationally.
REQ-016 Reset asserted mid-burst SHALL abandon the burst with no further writes; after release, arbitration restarts from channel 0.

Configuration
REQ-017 Macro FT_ARB_TRAILER_EN:
  - When defined: after each burst, TRAILER writes {8'h5A, beat counter[7:0]}, zero-extended to BUS_WIDTH, with ui_din_valid = !ui_din_full, then goes to IDLE.
  - When undefined: there is no TRAILER state, and DATA goes directly to IDLE.

Verification
REQ-018 Channel 2 sends 3 words 0x1111, 0x2222, 0x3333 (last on the third), full=0:
  - Without the macro: ft stream is 0xA502, 0x1111, 0x2222, 0x3333, then busy=0 after the next edge.
  - With the macro: a trailer 0x5A03 follows.
REQ-019 All four channels are continuously valid with 1-word messages: grants go 0,1,2,3,0 and headers are 0xA500, 0xA501, 0xA502, 0xA503, 0xA500.
REQ-020 MAX_BURST=4 and channel 0 streams 10 words without last: the first grant writes 4 data words, then channel 1 (if requesting) is served before channel 0 resumes with a new header 0xA500.
REQ-021 ui_din_full=1 for 5 cycles during the second data word: no ui_din_valid pulses, req_ready=0, the word is held, and it is written once after full drops.
REQ-022 rst_n is pulsed low for 1 cycle after 2 of 5 words: outputs clear immediately, and a new request on channel 3 gets header 0xA503.
